// File: rtl/arm_exe_pkg.sv
// Shared definitions for the ARM execute stage: ALU command codes,
// NZCV bit positions and operand-forwarding select codes.
package arm_exe_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    localparam logic [1:0] FWD_ID  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/arm_alu.sv
// Combinational ARM ALU: result, candidate NZCV and an arith flag telling
// the caller whether C/V are meaningful for this op.
module arm_alu
    import arm_exe_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [3:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          cin,
    output logic [DW-1:0] result,
    output logic [3:0]    nzcv,
    output logic          arith
);

    logic          sub;
    logic          ci;
    logic [DW-1:0] bop;
    logic [DW:0]   sum;

    always_comb begin
        arith = 1'b0;
        sub   = 1'b0;
        ci    = 1'b0;
        case (op)
            CMD_ADD: arith = 1'b1;
            CMD_ADC: begin
                arith = 1'b1;
                ci    = cin;
            end
            CMD_SUB: begin
                arith = 1'b1;
                sub   = 1'b1;
                ci    = 1'b1;
            end
            CMD_SBC: begin
                arith = 1'b1;
                sub   = 1'b1;
                ci    = cin;
            end
            default: ;
        endcase

        // subtraction as a + ~b + ci, so carry out is not-borrow
        bop = sub ? ~b : b;
        sum = {1'b0, a} + {1'b0, bop} + {{DW{1'b0}}, ci};

        case (op)
            CMD_MOV: result = b;
            CMD_MVN: result = ~b;
            CMD_AND: result = a & b;
            CMD_ORR: result = a | b;
            CMD_EOR: result = a ^ b;
            default: result = arith ? sum[DW-1:0] : '0;
        endcase

        nzcv[N_BIT] = result[DW-1];
        nzcv[Z_BIT] = (result == '0);
        nzcv[C_BIT] = sum[DW];
        nzcv[V_BIT] = (a[DW-1] == bop[DW-1]) &&
                      (sum[DW-1] != a[DW-1]);
    end

endmodule

// File: rtl/exe_stage.sv
// ARM execute stage: ALU, NZCV status, branch target, EXE/MEM register.
// Define EXE_FORWARD_EN to add operand-forwarding muxes for rn and store data.
module exe_stage
    import arm_exe_pkg::*;
#(
    parameter int DW    = 32,
    parameter int IMM_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             freeze,
    input  logic             flush,
    input  logic             id_valid,
    input  logic [3:0]       exe_cmd,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    input  logic             wb_en,
    input  logic             s_en,
    input  logic             b_en,
    input  logic [DW-1:0]    pc_in,
    input  logic [DW-1:0]    val_rn,
    input  logic [DW-1:0]    val2,
    input  logic [DW-1:0]    val_rm,
    input  logic [3:0]       dest,
    input  logic [IMM_W-1:0] imm24,
`ifdef EXE_FORWARD_EN
    input  logic [1:0]       sel_src1,
    input  logic [1:0]       sel_src2,
    input  logic [DW-1:0]    mem_fwd_val,
    input  logic [DW-1:0]    wb_fwd_val,
`endif
    output logic             exe_valid,
    output logic [DW-1:0]    alu_res,
    output logic [DW-1:0]    st_val,
    output logic [3:0]       dest_out,
    output logic             mem_r_out,
    output logic             mem_w_out,
    output logic             wb_out,
    output logic [3:0]       status,
    output logic             br_taken,
    output logic [DW-1:0]    br_addr
);

    logic [DW-1:0] src1;
    logic [DW-1:0] st_src;

`ifdef EXE_FORWARD_EN
    always_comb begin
        unique case (sel_src1)
            FWD_MEM: src1 = mem_fwd_val;
            FWD_WB:  src1 = wb_fwd_val;
            default: src1 = val_rn;
        endcase
        unique case (sel_src2)
            FWD_MEM: st_src = mem_fwd_val;
            FWD_WB:  st_src = wb_fwd_val;
            default: st_src = val_rm;
        endcase
    end
`else
    assign src1   = val_rn;
    assign st_src = val_rm;
`endif

    logic          is_mem;
    logic [3:0]    op;
    logic [DW-1:0] res;
    logic [3:0]    nzcv;
    logic          arith;

    // loads and stores always compute rn + op2 as the address
    assign is_mem = mem_r_en | mem_w_en;
    assign op     = is_mem ? CMD_ADD : exe_cmd;

    arm_alu #(.DW(DW)) u_alu (
        .op     (op),
        .a      (src1),
        .b      (val2),
        .cin    (status[C_BIT]),
        .result (res),
        .nzcv   (nzcv),
        .arith  (arith)
    );

    logic [DW-1:0] br_off;
    logic [DW-1:0] br_tgt;
    logic          st_upd;
    logic [3:0]    st_next;

    assign br_off = {{(DW-IMM_W){imm24[IMM_W-1]}}, imm24};
    assign br_tgt = pc_in + (br_off << 2);

    assign st_upd = id_valid & s_en & ~b_en & ~is_mem;

    always_comb begin
        st_next        = status;
        st_next[N_BIT] = nzcv[N_BIT];
        st_next[Z_BIT] = nzcv[Z_BIT];
        if (arith) begin
            st_next[C_BIT] = nzcv[C_BIT];
            st_next[V_BIT] = nzcv[V_BIT];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_valid <= 1'b0;
            alu_res   <= '0;
            st_val    <= '0;
            dest_out  <= '0;
            mem_r_out <= 1'b0;
            mem_w_out <= 1'b0;
            wb_out    <= 1'b0;
            status    <= '0;
            br_taken  <= 1'b0;
            br_addr   <= '0;
        end else if (!freeze) begin
            alu_res  <= res;
            st_val   <= st_src;
            dest_out <= dest;
            br_addr  <= br_tgt;
            if (flush) begin
                exe_valid <= 1'b0;
                mem_r_out <= 1'b0;
                mem_w_out <= 1'b0;
                wb_out    <= 1'b0;
                br_taken  <= 1'b0;
            end else begin
                exe_valid <= id_valid;
                mem_r_out <= mem_r_en & id_valid;
                mem_w_out <= mem_w_en & id_valid;
                wb_out    <= wb_en & id_valid;
                br_taken  <= b_en & id_valid;
                if (st_upd)
                    status <= st_next;
            end
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed literal checks plus
// randomized traffic against a behavioural model.
module tb_exe_stage;
    import arm_exe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic        id_valid = 1'b0;
    logic [3:0]  exe_cmd = '0;
    logic        mem_r_en = 1'b0;
    logic        mem_w_en = 1'b0;
    logic        wb_en = 1'b0;
    logic        s_en = 1'b0;
    logic        b_en = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] val_rn = '0;
    logic [31:0] val2 = '0;
    logic [31:0] val_rm = '0;
    logic [3:0]  dest = '0;
    logic [23:0] imm24 = '0;
    logic [1:0]  sel_src1 = '0;
    logic [1:0]  sel_src2 = '0;
    logic [31:0] mem_fwd_val = '0;
    logic [31:0] wb_fwd_val = '0;

    logic        exe_valid;
    logic [31:0] alu_res;
    logic [31:0] st_val;
    logic [3:0]  dest_out;
    logic        mem_r_out;
    logic        mem_w_out;
    logic        wb_out;
    logic [3:0]  status;
    logic        br_taken;
    logic [31:0] br_addr;

    exe_stage #(.DW(32), .IMM_W(24)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .freeze      (freeze),
        .flush       (flush),
        .id_valid    (id_valid),
        .exe_cmd     (exe_cmd),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .wb_en       (wb_en),
        .s_en        (s_en),
        .b_en        (b_en),
        .pc_in       (pc_in),
        .val_rn      (val_rn),
        .val2        (val2),
        .val_rm      (val_rm),
        .dest        (dest),
        .imm24       (imm24),
`ifdef EXE_FORWARD_EN
        .sel_src1    (sel_src1),
        .sel_src2    (sel_src2),
        .mem_fwd_val (mem_fwd_val),
        .wb_fwd_val  (wb_fwd_val),
`endif
        .exe_valid   (exe_valid),
        .alu_res     (alu_res),
        .st_val      (st_val),
        .dest_out    (dest_out),
        .mem_r_out   (mem_r_out),
        .mem_w_out   (mem_w_out),
        .wb_out      (wb_out),
        .status      (status),
        .br_taken    (br_taken),
        .br_addr     (br_addr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    localparam longint TWO32 = 64'sh1_0000_0000;

    // Reference ALU from exact integer arithmetic
    function automatic void model_alu(
        input  logic [3:0]  op,
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  logic        cin,
        output logic [31:0] r,
        output logic        c,
        output logic        v,
        output logic        ar);
        longint ua, ub, sa, sb, u, s;
        int ci;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ci = cin ? 1 : 0;
        u = 0; s = 0; r = '0; c = 1'b0; v = 1'b0; ar = 1'b1;
        case (op)
            CMD_ADD: begin u = ua + ub; s = sa + sb; end
            CMD_ADC: begin u = ua + ub + ci; s = sa + sb + ci; end
            CMD_SUB: begin u = ua - ub; s = sa - sb; end
            CMD_SBC: begin u = ua - ub - (1 - ci); s = sa - sb - (1 - ci); end
            default: ar = 1'b0;
        endcase
        if (ar) begin
            r = u[31:0];
            if (op == CMD_ADD || op == CMD_ADC) c = (u >= TWO32);
            else c = (u >= 0);
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else begin
            case (op)
                CMD_MOV: r = b;
                CMD_MVN: r = ~b;
                CMD_AND: r = a & b;
                CMD_ORR: r = a | b;
                CMD_EOR: r = a ^ b;
                default: r = '0;
            endcase
        end
    endfunction

    function automatic logic [31:0] pick(input logic [1:0] s,
        input logic [31:0] idv, input logic [31:0] mv, input logic [31:0] wv);
`ifdef EXE_FORWARD_EN
        return (s == 2'b01) ? mv : (s == 2'b10) ? wv : idv;
`else
        return (s == 2'b11) ? idv : (mv == wv) ? idv : idv;
`endif
    endfunction

    logic        m_valid = 0, m_r = 0, m_w = 0, m_wb = 0, m_br = 0, m_chk = 0;
    logic [31:0] m_res = 0, m_st = 0, m_braddr = 0;
    logic [3:0]  m_dest = 0, m_status = 0;
    logic [31:0] ma, mst, mr;
    logic        mc, mv, mar;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 0; m_r = 0; m_w = 0; m_wb = 0; m_br = 0; m_chk = 0;
            m_res = 0; m_st = 0; m_braddr = 0; m_dest = 0; m_status = 0;
        end else if (!freeze) begin
            ma  = pick(sel_src1, val_rn, mem_fwd_val, wb_fwd_val);
            mst = pick(sel_src2, val_rm, mem_fwd_val, wb_fwd_val);
            if (mem_r_en || mem_w_en) begin
                mr = ma + val2; mc = 0; mv = 0; mar = 0;
            end else begin
                model_alu(exe_cmd, ma, val2, m_status[1], mr, mc, mv, mar);
            end
            if (flush) begin
                m_valid = 0; m_r = 0; m_w = 0; m_wb = 0; m_br = 0; m_chk = 0;
            end else begin
                m_valid = id_valid;
                m_r  = mem_r_en & id_valid;
                m_w  = mem_w_en & id_valid;
                m_wb = wb_en & id_valid;
                m_br = b_en & id_valid;
                m_chk = id_valid & !b_en;
                m_res = mr;
                m_st = mst;
                m_dest = dest;
                m_braddr = 32'(longint'(pc_in) + longint'($signed(imm24)) * 4);
                if (id_valid && s_en && !b_en && !mem_r_en && !mem_w_en)
                    m_status = {mr[31], mr == 0,
                                mar ? mc : m_status[1],
                                mar ? mv : m_status[0]};
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("exe_valid", 32'(exe_valid), 32'(m_valid));
            chk("mem_r_out", 32'(mem_r_out), 32'(m_r));
            chk("mem_w_out", 32'(mem_w_out), 32'(m_w));
            chk("wb_out", 32'(wb_out), 32'(m_wb));
            chk("br_taken", 32'(br_taken), 32'(m_br));
            chk("status", 32'(status), 32'(m_status));
            if (m_valid) begin
                chk("st_val", st_val, m_st);
                chk("dest_out", 32'(dest_out), 32'(m_dest));
            end
            if (m_chk) chk("alu_res", alu_res, m_res);
            if (m_br) chk("br_addr", br_addr, m_braddr);
        end
    end

    task automatic set_op(input logic [3:0] cmd, input logic [31:0] rn,
                          input logic [31:0] v2, input logic s, input logic b,
                          input logic [31:0] pc, input logic [23:0] imm);
        id_valid = 1; exe_cmd = cmd; val_rn = rn; val2 = v2;
        s_en = s; b_en = b; pc_in = pc; imm24 = imm;
        mem_r_en = 0; mem_w_en = 0; wb_en = !b;
        val_rm = 32'h1234; dest = 4'd3; flush = 0; freeze = 0;
        sel_src1 = 0; sel_src2 = 0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(exe_valid), 0);
        chk("rst_alu", alu_res, 0);
        chk("rst_status", 32'(status), 0);
        chk("rst_br", 32'(br_taken), 0);
        chk("rst_braddr", br_addr, 0);
        rst_n = 1;

        set_op(CMD_ADD, 32'hFFFF_FFFF, 32'd1, 1, 0, 0, 0);
        @(negedge clk);
        chk("adds_res", alu_res, 0);
        chk("adds_st", 32'(status), 32'h6);

        set_op(CMD_ADC, 32'd5, 32'd3, 0, 0, 0, 0);
        @(negedge clk);
        chk("adc_res", alu_res, 32'd9);
        chk("adc_st", 32'(status), 32'h6);

        set_op(CMD_SUB, 32'h8000_0000, 32'd1, 1, 0, 0, 0);
        @(negedge clk);
        chk("subs_res", alu_res, 32'h7FFF_FFFF);
        chk("subs_st", 32'(status), 32'h3);

        set_op(4'd0, 0, 0, 1, 1, 32'h100, 24'hFFFFFE);
        @(negedge clk);
        chk("b_taken", 32'(br_taken), 1);
        chk("b_addr", br_addr, 32'hF8);
        chk("b_st", 32'(status), 32'h3);

        id_valid = 0; b_en = 0;
        @(negedge clk);
        chk("b_pulse", 32'(br_taken), 0);

        set_op(4'd0, 0, 0, 0, 1, 32'h100, 24'hFFFFFE);
        flush = 1;
        @(negedge clk);
        chk("flush_br", 32'(br_taken), 0);
        chk("flush_valid", 32'(exe_valid), 0);

        set_op(CMD_ADD, 32'd1, 32'd2, 1, 0, 0, 0);
        @(negedge clk);
        chk("pre_frz_res", alu_res, 32'd3);
        chk("pre_frz_st", 32'(status), 32'h0);
        for (int i = 0; i < 3; i++) begin
            set_op(CMD_SUB, $urandom, $urandom, 1, 0, 0, 0);
            freeze = 1;
            @(negedge clk);
            chk("frz_res", alu_res, 32'd3);
            chk("frz_st", 32'(status), 32'h0);
            chk("frz_valid", 32'(exe_valid), 1);
        end
        set_op(CMD_MOV, 0, 32'h55, 0, 0, 0, 0);
        @(negedge clk);
        chk("unfrz_res", alu_res, 32'h55);

`ifdef EXE_FORWARD_EN
        set_op(CMD_ADD, 32'd999, 32'd4, 0, 0, 0, 0);
        sel_src1 = 2'b01; mem_fwd_val = 32'd10;
        @(negedge clk);
        chk("fwd_res", alu_res, 32'd14);
`endif

        set_op(CMD_SUB, 0, 32'd1, 1, 0, 0, 0);
        @(negedge clk);
        chk("neg_res", alu_res, 32'hFFFF_FFFF);
        chk("neg_st", 32'(status), 32'h8);
        #2 rst_n = 0;
        #1;
        chk("arst_valid", 32'(exe_valid), 0);
        chk("arst_alu", alu_res, 0);
        chk("arst_st", 32'(status), 0);
        @(negedge clk);
        rst_n = 1;

        for (int i = 0; i < 3000; i++) begin
            id_valid = ($urandom_range(0, 7) != 0);
            exe_cmd = 4'($urandom);
            mem_r_en = ($urandom_range(0, 5) == 0);
            mem_w_en = !mem_r_en && ($urandom_range(0, 5) == 0);
            wb_en = 1'($urandom);
            s_en = 1'($urandom);
            b_en = ($urandom_range(0, 5) == 0);
            pc_in = $urandom;
            val_rn = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            val2 = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
            val_rm = $urandom;
            dest = 4'($urandom);
            imm24 = 24'($urandom);
            freeze = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 7) == 0);
            sel_src1 = 2'($urandom);
            sel_src2 = 2'($urandom);
            mem_fwd_val = $urandom;
            wb_fwd_val = $urandom;
            @(negedge clk);
        end
        freeze = 0; flush = 0; id_valid = 0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
